regfile_lsx: RTL and testbench

Parametrised successor register file for the single-cycle MIPS core. It provides two asynchronous read ports and an immediate write port with byte/halfword/link extraction. It adds a single-entry outstanding-load slot so a multi-cycle data memory can return load data later, with a hazard flag for the controller. It sits between decode (read addresses) and write-back / data memory.

---
 rtl/regfile_lsx.sv | 120 ++++++++++++
 tb/tb_regfile_lsx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_lsx.sv
// regfile_lsx: MIPS register file with load extraction, link write and one outstanding-load slot
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   raddr_a/b -> rdata_a/b, jalpc   two combinational read ports; jalpc = rdata_a word address
//   we, waddr, wmode, woff, wdata   immediate write with word/lb/lbu/lh/lhu/link extraction
//   pc                              current word PC, used by link mode
//   ld_issue, ld_dst, ld_mode, ld_off       start an outstanding load
//   ld_ret_valid, ld_ret_data               load data returned by memory
//   ld_busy, hazard, misalign               slot status, pending-load conflict, odd halfword offset
// Optional: define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_lsx #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 30,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [PC_W-1:0]   jalpc,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wmode,
  input  logic [1:0]        woff,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PC_W-1:0]   pc,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic [2:0]        ld_mode,
  input  logic [1:0]        ld_off,
  input  logic              ld_ret_valid,
  input  logic [DATA_W-1:0] ld_ret_data,
  output logic              ld_busy,
  output logic              hazard,
  output logic              misalign
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [2:0] M_LH = 3'd3, M_LHU = 3'd4, M_LINK = 3'd5;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_ld_busy;
  logic [ADDR_W-1:0] r_ld_dst;
  logic [2:0]        r_ld_mode;
  logic [1:0]        r_ld_off;
  logic [PC_W-1:0]   w_pc_inc;
  logic [DATA_W:0]   w_imm_ext;
  logic [DATA_W:0]   w_ld_ext;
  logic [DATA_W-1:0] w_imm_val;
  logic [DATA_W-1:0] w_ld_val;
  logic [ADDR_W-1:0] w_imm_addr;
  logic              w_imm_we;
  logic              w_ld_we;
  logic              w_ld_accept;
  // Returns {valid, value}; reserved modes and odd halfword offsets are invalid.
  function automatic logic [DATA_W:0] f_extract(input logic [2:0] mode, input logic [1:0] off,
                                                input logic [DATA_W-1:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[8*off +: 8];
    h = data[16*off[1] +: 16];
    return mode == 3'd0  ? {1'b1, data} :
           mode == 3'd1  ? {1'b1, {(DATA_W-8){b[7]}}, b} :
           mode == 3'd2  ? {1'b1, {(DATA_W-8){1'b0}}, b} :
           mode == M_LH  ? {~off[0], {(DATA_W-16){h[15]}}, h} :
           mode == M_LHU ? {~off[0], {(DATA_W-16){1'b0}}, h} :
                           {1'b0, {DATA_W{1'b0}}};
  endfunction
  // Read with optional forwarding: load return beats the immediate write.
  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return a == '0                       ? '0 :
           (w_ld_we && r_ld_dst == a)    ? w_ld_val :
           (w_imm_we && w_imm_addr == a) ? w_imm_val :
                                           r_regs[a];
`else
    return a == '0 ? '0 : r_regs[a];
`endif
  endfunction
  always_comb begin
    w_pc_inc    = pc + PC_W'(1);
    w_imm_ext   = f_extract(wmode, woff, wdata);
    w_ld_ext    = f_extract(r_ld_mode, r_ld_off, ld_ret_data);
    w_imm_val   = wmode == M_LINK ? DATA_W'({w_pc_inc, 2'b00}) : w_imm_ext[DATA_W-1:0];
    w_ld_val    = w_ld_ext[DATA_W-1:0];
    w_imm_addr  = wmode == M_LINK ? LINK_IDX : waddr;
    w_imm_we    = we && (wmode == M_LINK || w_imm_ext[DATA_W]) && w_imm_addr != '0;
    w_ld_we     = r_ld_busy && ld_ret_valid && w_ld_ext[DATA_W] && r_ld_dst != '0;
    w_ld_accept = ld_issue && (!r_ld_busy || ld_ret_valid);
    rdata_a     = f_read(raddr_a);
    rdata_b     = f_read(raddr_b);
    jalpc       = rdata_a[DATA_W-1:2];
    ld_busy     = r_ld_busy;
    misalign    = we && (wmode == M_LH || wmode == M_LHU) && woff[0];
    hazard      = r_ld_busy && r_ld_dst != '0 &&
                  (raddr_a == r_ld_dst || raddr_b == r_ld_dst ||
                   (we && waddr == r_ld_dst) || (we && wmode == M_LINK && LINK_IDX == r_ld_dst));
  end
  // The load return is assigned last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_ld_busy <= 1'b0;
      r_ld_dst  <= '0;
      r_ld_mode <= '0;
      r_ld_off  <= '0;
    end else begin
      if (w_imm_we) r_regs[w_imm_addr] <= w_imm_val;
      if (w_ld_we) r_regs[r_ld_dst] <= w_ld_val;
      r_ld_busy <= w_ld_accept || (r_ld_busy && !ld_ret_valid);
      if (w_ld_accept) begin
        r_ld_dst  <= ld_dst;
        r_ld_mode <= ld_mode;
        r_ld_off  <= ld_off;
      end
    end
  end
endmodule

// File: tb/tb_regfile_lsx.sv
// tb_regfile_lsx: directed checks of regfile_lsx extraction, link, load slot and reset
module tb_regfile_lsx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr_a, raddr_b, waddr, ld_dst;
  logic [31:0] rdata_a, rdata_b, wdata, ld_ret_data;
  logic [29:0] jalpc, pc;
  logic        we, ld_issue, ld_ret_valid, ld_busy, hazard, misalign;
  logic [2:0]  wmode, ld_mode;
  logic [1:0]  woff, ld_off;
  int n_cmp = 0;
  int n_err = 0;
  regfile_lsx dut (
    .clk(clk), .rst_n(rst_n), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .jalpc(jalpc),
    .we(we), .waddr(waddr), .wmode(wmode), .woff(woff), .wdata(wdata), .pc(pc),
    .ld_issue(ld_issue), .ld_dst(ld_dst), .ld_mode(ld_mode), .ld_off(ld_off),
    .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
    .ld_busy(ld_busy), .hazard(hazard), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd_a(input logic [4:0] a, input string tag, input logic [31:0] exp);
    raddr_a = a;
    #1;
    chk(tag, rdata_a, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [2:0] m, input logic [1:0] o, input logic [31:0] d);
    we = 1'b1; waddr = a; wmode = m; woff = o; wdata = d;
    tick;
    we = 1'b0;
  endtask
  logic [2:0]  sw_mode [8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
  logic [31:0] sw_exp  [8] = '{32'hFFFFFF80, 32'h0000007F, 32'h00000001, 32'hFFFFFF80,
                               32'h00000080, 32'h0000007F, 32'h00000001, 32'h00000080};
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; raddr_a = '0; raddr_b = 5'd1; we = 1'b0; waddr = '0; wmode = '0; woff = '0;
    wdata = '0; pc = '0; ld_issue = 1'b0; ld_dst = '0; ld_mode = '0; ld_off = '0;
    ld_ret_valid = 1'b0; ld_ret_data = '0;
    #12;
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 32; i++) rd_a(5'(i), $sformatf("rst_r%0d", i), 32'h0);
    wr(5'd0, 3'd0, 2'd0, 32'hFFFFFFFF);
    rd_a(5'd0, "r0_discard", 32'h0);
    for (int i = 0; i < 8; i++) begin
      wr(5'd3, sw_mode[i], 2'(i % 4), 32'h80017F80);
      rd_a(5'd3, $sformatf("sweep_m%0d_o%0d", sw_mode[i], i % 4), sw_exp[i]);
    end
    wr(5'd3, 3'd3, 2'd2, 32'h80010000);
    rd_a(5'd3, "lh_off2", 32'hFFFF8001);
    we = 1'b1; waddr = 5'd3; wmode = 3'd4; woff = 2'd1; wdata = 32'h00001234;
    #1;
    chk("misalign_lhu", 32'(misalign), 32'd1);
    tick;
    we = 1'b0;
    #1;
    chk("misalign_idle", 32'(misalign), 32'd0);
    rd_a(5'd3, "misalign_nowrite", 32'hFFFF8001);
    wr(5'd31, 3'd0, 2'd0, 32'hDEADBEEF);
    pc = 30'h3FFFFFFF;
    wr(5'd3, 3'd5, 2'd0, 32'h0);
    rd_a(5'd31, "link_wrap", 32'h0);
    rd_a(5'd3, "link_ignores_waddr", 32'hFFFF8001);
    pc = 30'h00000010;
    wr(5'd3, 3'd5, 2'd0, 32'h0);
    rd_a(5'd31, "link_r31", 32'h00000044);
    chk("jalpc", 32'(jalpc), 32'h00000011);
    wr(5'd6, 3'd7, 2'd0, 32'h11111111);
    rd_a(5'd6, "reserved_nowrite", 32'h0);
    raddr_a = '0; raddr_b = 5'd1;
    ld_issue = 1'b1; ld_dst = 5'd5; ld_mode = 3'd1; ld_off = 2'd1;
    tick;
    ld_issue = 1'b1; ld_dst = 5'd6; ld_mode = 3'd0; ld_off = 2'd0;
    #1;
    chk("ld_busy", 32'(ld_busy), 32'd1);
    chk("hazard_idle", 32'(hazard), 32'd0);
    raddr_b = 5'd5;
    #1;
    chk("hazard_rb", 32'(hazard), 32'd1);
    raddr_b = 5'd1;
    tick;
    ld_issue = 1'b0;
    tick;
    we = 1'b1; waddr = 5'd5; wmode = 3'd0; woff = 2'd0; wdata = 32'h00001234;
    ld_ret_valid = 1'b1; ld_ret_data = 32'h00009C00;
    #1;
    chk("hazard_we", 32'(hazard), 32'd1);
    tick;
    we = 1'b0; ld_ret_valid = 1'b0;
    #1;
    chk("ret_busy_clr", 32'(ld_busy), 32'd0);
    rd_a(5'd5, "ret_wins", 32'hFFFFFF9C);
    rd_a(5'd6, "busy_issue_ignored", 32'h0);
    ld_ret_valid = 1'b1; ld_ret_data = 32'h77777777;
    tick;
    ld_ret_valid = 1'b0;
    rd_a(5'd5, "ret_while_empty", 32'hFFFFFF9C);
    ld_issue = 1'b1; ld_dst = 5'd8; ld_mode = 3'd0; ld_off = 2'd0;
    tick;
    ld_dst = 5'd9; ld_mode = 3'd2; ld_off = 2'd3;
    ld_ret_valid = 1'b1; ld_ret_data = 32'hAAAA5555;
    we = 1'b1; waddr = 5'd10; wmode = 3'd0; wdata = 32'h0000BEEF;
    tick;
    ld_issue = 1'b0; ld_ret_valid = 1'b0; we = 1'b0;
    rd_a(5'd8, "ret_word", 32'hAAAA5555);
    rd_a(5'd10, "diff_index_write", 32'h0000BEEF);
    chk("reissue_busy", 32'(ld_busy), 32'd1);
    ld_ret_valid = 1'b1; ld_ret_data = 32'h7F000000;
    tick;
    ld_ret_valid = 1'b0;
    rd_a(5'd9, "ret_lbu_off3", 32'h0000007F);
    ld_issue = 1'b1; ld_dst = 5'd0; ld_mode = 3'd0;
    tick;
    ld_issue = 1'b0; raddr_a = 5'd0;
    #1;
    chk("dst0_busy", 32'(ld_busy), 32'd1);
    chk("dst0_nohazard", 32'(hazard), 32'd0);
    ld_ret_valid = 1'b1; ld_ret_data = 32'h12345678;
    tick;
    ld_ret_valid = 1'b0;
    rd_a(5'd0, "dst0_discard", 32'h0);
    ld_issue = 1'b1; ld_dst = 5'd10; ld_mode = 3'd0;
    tick;
    ld_issue = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midload_busy_clr", 32'(ld_busy), 32'd0);
    rst_n = 1'b1;
    ld_ret_valid = 1'b1; ld_ret_data = 32'hFFFFFFFF;
    tick;
    ld_ret_valid = 1'b0;
    rd_a(5'd10, "midload_ret_ignored", 32'h0);
    chk("midload_busy", 32'(ld_busy), 32'd0);
    we = 1'b1; waddr = 5'd7; wmode = 3'd0; woff = 2'd0; wdata = 32'h0000CAFE;
    raddr_a = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre", rdata_a, 32'h0000CAFE);
`else
    chk("nobypass_pre", rdata_a, 32'h0);
`endif
    tick;
    we = 1'b0;
    rd_a(5'd7, "r7_post", 32'h0000CAFE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
